lcd_timing_gen: RTL and testbench



---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_pattern_gen.sv | 38 +++
 rtl/lcd_timing_gen.sv | 142 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, mode encoding, colour-bar table and width helper
// for the LCD timing generator.
package lcd_pkg;

    typedef enum logic [1:0] {MODE_EXT, MODE_BARS, MODE_SOLID, MODE_CHECK} mode_e;
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

    // {r, g, b} saturation flags: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_TAB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    function automatic int w_of(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: combinational test-pattern colour for a pixel position.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int XW = 9,
    parameter int YW = 9,
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5
) (
    input  logic [XW-1:0]  x,
    input  logic [YW-1:0]  y,
    input  mode_e          mode,
    output logic [R_W-1:0] r,
    output logic [G_W-1:0] g,
    output logic [B_W-1:0] b
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;
    logic [2:0] rgb;
    logic       chk;

    always_comb begin
        bar = BAR_TAB[3'(x / XW'(BAR_W))];
        // bit 4 of x/y; narrow rasters simply have it tied low
        chk = (|(x & XW'(16))) ^ (|(y & YW'(16)));
        rgb = mode == MODE_BARS  ? bar :
              mode == MODE_SOLID ? 3'b111 :
              mode == MODE_CHECK ? {3{chk}} : 3'b000;
        r = {R_W{rgb[2]}};
        g = {G_W{rgb[1]}};
        b = {B_W{rgb[0]}};
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB panel timing generator; issues upstream pixel requests and
// aligns sync, DEN and colour through a PIX_LAT-deep delay line.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int H_FP = 8,
    parameter int H_SYNC = 4,
    parameter int H_BP = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP = 8,
    parameter int V_SYNC = 4,
    parameter int V_BP = 12,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int R_W = 5,
    parameter int G_W = 6,
    parameter int B_W = 5,
    parameter int PIX_LAT = 1,
    localparam int XW = w_of(H_ACTIVE),
    localparam int YW = w_of(V_ACTIVE)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [1:0]     mode,
    output logic           pix_req,
    output logic [XW-1:0]  pix_x,
    output logic [YW-1:0]  pix_y,
    input  logic [R_W-1:0] pix_r,
    input  logic [G_W-1:0] pix_g,
    input  logic [B_W-1:0] pix_b,
    output logic [R_W-1:0] lcd_r,
    output logic [G_W-1:0] lcd_g,
    output logic [B_W-1:0] lcd_b,
    output logic           lcd_hsync,
    output logic           lcd_vsync,
    output logic           lcd_den,
    output logic           frame_start,
    output logic           line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_A = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_S0 = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_S1 = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_L = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_A = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_S0 = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_S1 = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_L = VW'(V_TOTAL - 1);
    localparam logic HSP = 1'(HS_POL);
    localparam logic VSP = 1'(VS_POL);

    typedef struct packed {
        logic          act;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          ls;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        mode_e         mode;
    } stage_t;

    state_e         state, state_nx;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    mode_e          mode_q, mode_cur;
    logic           run, h_last, f_last;
    stage_t         s0, tap;
    stage_t         dly [1:PIX_LAT];
    logic [R_W-1:0] pat_r;
    logic [G_W-1:0] pat_g;
    logic [B_W-1:0] pat_b;

    always_comb begin
        run = state != IDLE;
        h_last = h_cnt == H_L;
        f_last = h_last && v_cnt == V_L;
        // RUN and STOPPING differ only in whether the frame end drops to IDLE
        state_nx = enable ? RUN : (state == IDLE || f_last) ? IDLE : STOPPING;
        mode_cur = (run && h_cnt == '0 && v_cnt == '0) ? mode_e'(mode) : mode_q;
        s0 = '0;
        s0.act = run && h_cnt < H_A && v_cnt < V_A;
        s0.hs = run && h_cnt >= H_S0 && h_cnt < H_S1;
        s0.vs = run && v_cnt >= V_S0 && v_cnt < V_S1;
        s0.fs = run && h_cnt == '0 && v_cnt == '0;
        s0.ls = run && h_cnt == '0 && v_cnt < V_A;
        s0.x = h_cnt[XW-1:0];
        s0.y = v_cnt[YW-1:0];
        s0.mode = mode_cur;
        pix_req = s0.act && mode_cur == MODE_EXT;
        pix_x = s0.x;
        pix_y = s0.y;
    end

    assign tap = dly[PIX_LAT];

    lcd_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .XW(XW), .YW(YW), .R_W(R_W), .G_W(G_W), .B_W(B_W)
    ) u_pat (
        .x(tap.x), .y(tap.y), .mode(tap.mode), .r(pat_r), .g(pat_g), .b(pat_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            mode_q <= MODE_EXT;
            for (int i = 1; i <= PIX_LAT; i++) dly[i] <= '0;
            lcd_r <= '0;
            lcd_g <= '0;
            lcd_b <= '0;
            lcd_hsync <= ~HSP;
            lcd_vsync <= ~VSP;
            lcd_den <= 1'b0;
            frame_start <= 1'b0;
            line_start <= 1'b0;
        end else begin
            state <= state_nx;
            h_cnt <= !run || h_last ? '0 : h_cnt + 1'b1;
            v_cnt <= !run ? '0 : !h_last ? v_cnt : v_cnt == V_L ? '0 : v_cnt + 1'b1;
            mode_q <= mode_cur;
            dly[1] <= s0;
            for (int i = 2; i <= PIX_LAT; i++) dly[i] <= dly[i-1];
            lcd_r <= tap.act ? (tap.mode == MODE_EXT ? pix_r : pat_r) : '0;
            lcd_g <= tap.act ? (tap.mode == MODE_EXT ? pix_g : pat_g) : '0;
            lcd_b <= tap.act ? (tap.mode == MODE_EXT ? pix_b : pat_b) : '0;
            lcd_hsync <= tap.hs ? HSP : ~HSP;
            lcd_vsync <= tap.vs ? VSP : ~VSP;
            lcd_den <= tap.act;
            frame_start <= tap.fs;
            line_start <= tap.ls;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: scoreboard bench for lcd_timing_gen on a 14x7 raster with
// PIX_LAT=2; expected outputs are queued per clock and checked three clocks later.
module tb_lcd_timing_gen;

    localparam int HT = 14;
    localparam int FT = HT * 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       pix_req;
    logic [2:0] pix_x;
    logic [1:0] pix_y;
    logic [4:0] pix_r, pix_b, lcd_r, lcd_b;
    logic [5:0] pix_g, lcd_g;
    logic       lcd_hsync, lcd_vsync, lcd_den, frame_start, line_start;

    typedef struct {
        int          due;
        int          p;
        logic [20:0] v;
    } ent_t;

    ent_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pos = -1;
    logic       en_q = 1'b0;
    logic [1:0] m_mode = 2'd0;
    logic [4:0] up0 = 5'd0, up1 = 5'd0;

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .R_W(5), .G_W(6), .B_W(5), .PIX_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_den(lcd_den),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk = ~clk;

    // upstream source: pixel value x+8y, returned two clocks after the request
    always @(posedge clk) begin
        up0 <= pix_req ? 5'(pix_x + 8 * pix_y) : 5'd0;
        up1 <= up0;
    end
    assign pix_r = up1;
    assign pix_g = {1'b0, up1};
    assign pix_b = ~up1;

    function automatic logic is_act(input int p);
        return p >= 0 && p % HT < 8 && p / HT < 4;
    endfunction

    function automatic logic [20:0] expect_out(input int p, input logic [1:0] md);
        int h, v;
        logic [4:0] pv, r, b;
        logic [5:0] g;
        h = p % HT;
        v = p / HT;
        pv = 5'(h + 8 * v);
        r = '0;
        g = '0;
        b = '0;
        if (is_act(p)) begin
            case (md)
                2'd0: begin r = pv; g = {1'b0, pv}; b = ~pv; end
                2'd1: begin r = {5{(h % 4) < 2}}; g = {6{h < 4}}; b = {5{h % 2 == 0}}; end
                2'd2: begin r = '1; g = '1; b = '1; end
                default: begin
                    r = {5{((h / 16) ^ (v / 16)) % 2 == 1}};
                    g = {6{r[0]}};
                    b = r;
                end
            endcase
        end
        return {is_act(p), !(p >= 0 && h >= 10 && h < 12), !(p >= 0 && v == 5),
                p == 0, p >= 0 && h == 0 && v < 4, r, g, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " den"}, 32'(lcd_den), 32'd0);
        chk({tag, " hsync"}, 32'(lcd_hsync), 32'd1);
        chk({tag, " vsync"}, 32'(lcd_vsync), 32'd1);
        chk({tag, " rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
        chk({tag, " starts"}, 32'({frame_start, line_start}), 32'd0);
        chk({tag, " pix_req"}, 32'(pix_req), 32'd0);
        chk({tag, " pix_xy"}, 32'({pix_x, pix_y}), 32'd0);
    endtask

    task automatic tick(input logic en, input logic [1:0] md);
        logic [20:0] obs;
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        pos = (pos < 0 || pos == FT - 1) ? (en_q ? 0 : -1) : pos + 1;
        enable = en;
        mode = md;
        en_q = en;
        if (pos == 0) m_mode = md;
        #1;
        obs = {lcd_den, lcd_hsync, lcd_vsync, frame_start, line_start, lcd_r, lcd_g, lcd_b};
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk($sformatf("out p=%0d", q[0].p), 32'(obs), 32'(q[0].v));
            void'(q.pop_front());
        end
        chk($sformatf("pix_req p=%0d", pos), 32'(pix_req), 32'(is_act(pos) && m_mode == 2'd0));
        if (is_act(pos) && m_mode == 2'd0) begin
            chk($sformatf("pix_x p=%0d", pos), 32'(pix_x), 32'(pos % HT));
            chk($sformatf("pix_y p=%0d", pos), 32'(pix_y), 32'(pos / HT));
        end
        e.due = cyc + 3;
        e.p = pos;
        e.v = expect_out(pos, m_mode);
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] md);
        repeat (n) tick(en, md);
    endtask

    task automatic run_to(input int target, input logic en, input logic [1:0] md);
        int n = 0;
        do begin
            tick(en, md);
            n++;
        end while (pos != target && n < 2 * FT);
        assert (pos == target) else begin
            errors++;
            $error("FAIL run_to: reached %0d expected %0d", pos, target);
        end
    endtask

    initial begin
        ent_t e;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        reset = 1'b0;
        run(3, 1'b0, 2'd0);
        run(1, 1'b1, 2'd0);
        run(2 * FT + 5, 1'b1, 2'd0);
        run_to(0, 1'b1, 2'd1);
        run_to(28, 1'b1, 2'd1);
        run_to(0, 1'b1, 2'd2);
        run_to(0, 1'b1, 2'd3);
        run_to(16, 1'b1, 2'd0);
        run(100, 1'b0, 2'd0);
        run(1, 1'b1, 2'd0);
        run_to(16, 1'b1, 2'd0);
        run(20, 1'b0, 2'd0);
        run_to(0, 1'b1, 2'd0);
        run_to(33, 1'b1, 2'd0);
        #1 reset = 1'b1;
        #1;
        chk_reset("async reset");
        q.delete();
        for (int i = 1; i <= 3; i++) begin
            e.due = cyc + i;
            e.p = -1;
            e.v = expect_out(-1, 2'd0);
            q.push_back(e);
        end
        pos = -1;
        reset = 1'b0;
        run(FT + 12, 1'b1, 2'd0);
        run(8, 1'b0, 2'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
